alu_dmem_stage: RTL and testbench
=================================

Name: alu_dmem_stage

Overview:
- Execute/memory stage for the single-cycle CPU datapath.
- Combines a 32-bit ALU, built around a dedicated 32-bit adder, with a word-organised data memory.
- The memory address is the ALU result, as in load/store address generation (base + offset).
- ALU is purely combinational; memory writes are synchronous, memory reads are combinational.

Parameters:
- DATA_W, 32, datapath width.
- RAM_DEPTH, 256, data memory size in bytes; must be a power of two and a multiple of 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset; clears the data memory.
- a  in  DATA_W  ALU operand A (base register value).
- b  in  DATA_W  ALU operand B (register value or offset).
- alu_ctr  in  4  ALU operation select.
- y  out  DATA_W  ALU result; also the memory byte address.
- zero  out  1  high when y == 0.
- cout  out  1  adder carry-out.
- cs_ram  in  1  memory chip select.
- we  in  1  write enable.
- oe  in  1  output enable.
- d_in  in  DATA_W  write data.
- d_out  out  DATA_W  read data.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- ALU op encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT: signed; y = 32'h1 if a < b, else 0.
  - 1100 NOR.
  - Any other code: y = 0.
- Arithmetic:
  - ADD = a + b, carry-in 0.
  - SUB = a + ~b with carry-in 1.
  - SLT derives its result from the SUB sum sign XOR signed overflow.
  - All results wrap modulo 2^32.
- cout is the adder carry-out for ADD, SUB and SLT; 0 for all other ops.
- zero = (y == 0), including the "other code" case, where zero = 1.
- ALU outputs are combinational with zero latency and are independent of rst.
- Memory organisation: RAM_DEPTH/4 words of 32 bits. Word index = y[log2(RAM_DEPTH)-1:2].
  - y[1:0] are ignored (accesses are word-aligned).
  - Upper address bits are ignored, so addresses wrap around the memory.
- Write: on rising clk, when cs_ram & we & !rst, mem[index] <= d_in.
- Read:
  - d_out = mem[index] combinationally when cs_ram & oe & !we.
  - Otherwise d_out = 0.
  - we takes priority over oe when both are high: the write occurs and d_out = 0.
- Reset:
  - rst high asynchronously clears every memory word to 0. While rst is high, writes are blocked and reads return 0.
  - Deasserting rst mid-sequence leaves memory zeroed; the next enabled edge writes normally.
- Write/read timing: a read of a word written on an edge returns the new data immediately after that edge. The same-cycle read before the edge returns old data.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), the signed overflow for ADD/SUB/SLT (operand signs equal and result sign differs, after the b inversion for SUB); 0 for other ops.
- Undefined: port absent; overflow is used only internally for SLT.

Decomposition:
- Shared package alu_dmem_pkg holds:
  - the 4-bit ALU op localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
  - DATA_W;
  - a typedef for the op field.
- One sub-module is natural: add32_cla, a 32-bit adder with ports a, b, cin, sum, cout, built from 4-bit carry-lookahead groups. It is instantiated once and shared by ADD/SUB/SLT.

Test Plan:
- ALU ops, each followed by a check of y and zero:
  - a=0, b=8, ADD -> y=0x8, zero=0, cout=0.
  - a=0, b=12, OR -> y=0xC.
  - a=12, b=8, SUB -> y=0x4, cout=1.
  - a=8, b=12, AND -> y=0x8.
  - a=12, b=12, SLT -> y=0, zero=1.
  - a=8, b=12, NOR -> y=0xFFFFFFF3.
  - a=0, b=12, op=1111 -> y=0, zero=1.
- Adder edges:
  - a=0, b=0xFFFFFFFF, ADD -> y=0xFFFFFFFF, cout=0.
  - a=0x7FFFFFFF, b=0x7FFFFFFF, ADD -> y=0xFFFFFFFE, cout=0 (ovf=1 with ALU_OVERFLOW_EN).
  - a=0, b=1, SUB -> y=0xFFFFFFFF, cout=0.
  - a=0x1C, b=0x08, ADD -> y=0x24.
- SLT signed: a=0xFFFFFFFF, b=1 -> y=1; a=1, b=0xFFFFFFFF -> y=0.
- Memory fill and readback:
  - Reset, then with cs_ram=1, we=1, ADD a=0, b=i*4, d_in=i for i=0..30 on successive edges.
  - Then set we=0, oe=1 and read each address -> d_out=i.
  - Read with oe=0 or cs_ram=0 -> d_out=0.
- Wrap and alignment:
  - Write 0xDEADBEEF at y=0x04; read at y=0x104 and at y=0x07 -> 0xDEADBEEF.
- Reset mid-operation:
  - After the fill, pulse rst asynchronously between edges; every address reads 0 immediately.
  - An edge with we=1 while rst is high leaves memory at 0.

Source files
------------

// File: rtl/alu_dmem_pkg.sv
// alu_dmem_pkg: shared ALU op encodings, op field type and datapath width
package alu_dmem_pkg;
    localparam int DATA_W = 32;
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;
    localparam alu_op_t ALU_NOR = 4'b1100;
endpackage

// File: rtl/add32_cla.sv
// add32_cla: 32-bit adder from eight 4-bit carry-lookahead groups
module add32_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p, g;
    logic [7:0]  grp_p, grp_g;
    logic [8:0]  gc;
    assign p = a ^ b;
    assign g = a & b;
    for (genvar i = 0; i < 8; i++) begin : grp
        logic [3:0] gp, gg;
        logic [3:0] c;
        assign gp = p[4*i +: 4];
        assign gg = g[4*i +: 4];
        assign c[0] = gc[i];
        assign c[1] = gg[0] | (gp[0] & gc[i]);
        assign c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[i]);
        assign c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & gc[i]);
        assign grp_g[i] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
        assign grp_p[i] = &gp;
        assign sum[4*i +: 4] = gp ^ c;
    end
    // group carries from group generate/propagate, independent of in-group carries
    always_comb begin
        gc[0] = cin;
        for (int k = 0; k < 8; k++) gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
    end
    assign cout = gc[8];
endmodule

// File: rtl/alu_dmem_stage.sv
// alu_dmem_stage: 32-bit ALU feeding a word-organised data memory; ALU_OVERFLOW_EN adds an ovf port
module alu_dmem_stage #(
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alu_ctr,
    output logic [DATA_W-1:0] y,
    output logic              zero,
    output logic              cout,
    input  logic              cs_ram,
    input  logic              we,
    input  logic              oe,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out
`ifdef ALU_OVERFLOW_EN
    ,
    output logic              ovf
`endif
);
    import alu_dmem_pkg::*;
    localparam int AW    = $clog2(RAM_DEPTH);
    localparam int WORDS = RAM_DEPTH / 4;
    logic              sub, arith, carry, ovf_i;
    logic [DATA_W-1:0] bb, sum;
    logic [AW-3:0]     idx;
    logic [DATA_W-1:0] mem [WORDS];
    assign sub   = (alu_ctr == ALU_SUB) || (alu_ctr == ALU_SLT);
    assign arith = sub || (alu_ctr == ALU_ADD);
    assign bb    = sub ? ~b : b;
    add32_cla u_add (.a(a), .b(bb), .cin(sub), .sum(sum), .cout(carry));
    assign ovf_i = (a[DATA_W-1] == bb[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    // result select; unknown op codes give zero
    always_comb begin
        y = (alu_ctr == ALU_AND) ? (a & b) :
            (alu_ctr == ALU_OR)  ? (a | b) :
            (alu_ctr == ALU_ADD || alu_ctr == ALU_SUB) ? sum :
            (alu_ctr == ALU_SLT) ? {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ovf_i} :
            (alu_ctr == ALU_NOR) ? ~(a | b) : '0;
    end
    assign zero = (y == '0);
    assign cout = arith & carry;
`ifdef ALU_OVERFLOW_EN
    assign ovf = arith & ovf_i;
`endif
    assign idx = y[AW-1:2];
    // word writes on the clock; reset wipes the whole array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int k = 0; k < WORDS; k++) mem[k] <= '0;
        else if (cs_ram && we) mem[idx] <= d_in;
    end
    assign d_out = (cs_ram && oe && !we && !rst) ? mem[idx] : '0;
endmodule

// File: tb/tb_alu_dmem_stage.sv
// tb_alu_dmem_stage: directed self-checking bench for alu_dmem_stage
module tb_alu_dmem_stage;
    import alu_dmem_pkg::*;
    logic        clk = 0, rst = 0;
    logic [31:0] a = 0, b = 0, d_in = 0;
    logic [3:0]  alu_ctr = ALU_AND;
    logic        cs_ram = 0, we = 0, oe = 0;
    logic [31:0] y, d_out;
    logic        zero, cout;
    int          checks = 0, failures = 0;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    alu_dmem_stage dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .alu_ctr(alu_ctr),
        .y(y), .zero(zero), .cout(cout),
        .cs_ram(cs_ram), .we(we), .oe(oe), .d_in(d_in), .d_out(d_out)
`ifdef ALU_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic alu(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] op);
        a = ia;
        b = ib;
        alu_ctr = op;
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cs_ram = 1; we = 1; oe = 0; d_in = data;
        alu(0, addr, ALU_ADD);
        @(posedge clk);
        #1;
        we = 0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cs_ram = 1; we = 0; oe = 1;
        alu(0, addr, ALU_ADD);
        check(tag, d_out, exp);
    endtask

    initial begin
        #2 rst = 1;
        cs_ram = 1; oe = 1;
        #1 check("rst_dout", d_out, 0);
        #3 rst = 0;

        alu(0, 8, ALU_ADD);        check("add_y", y, 32'h8); check("add_z", zero, 0); check("add_c", cout, 0);
        alu(0, 12, ALU_OR);        check("or_y", y, 32'hC); check("or_z", zero, 0);
        alu(12, 8, ALU_SUB);       check("sub_y", y, 32'h4); check("sub_c", cout, 1);
        alu(8, 12, ALU_AND);       check("and_y", y, 32'h8);
        alu(12, 12, ALU_SLT);      check("slt_eq_y", y, 0); check("slt_eq_z", zero, 1);
        alu(8, 12, ALU_NOR);       check("nor_y", y, 32'hFFFFFFF3); check("nor_c", cout, 0);
        alu(0, 12, 4'b1111);       check("other_y", y, 0); check("other_z", zero, 1);
        alu(0, 32'hFFFFFFFF, ALU_ADD); check("addmax_y", y, 32'hFFFFFFFF); check("addmax_c", cout, 0);
        alu(32'hFFFFFFFF, 1, ALU_ADD); check("addwrap_y", y, 0); check("addwrap_c", cout, 1); check("addwrap_z", zero, 1);
        alu(32'h7FFFFFFF, 32'h7FFFFFFF, ALU_ADD); check("addovf_y", y, 32'hFFFFFFFE); check("addovf_c", cout, 0);
`ifdef ALU_OVERFLOW_EN
        check("addovf_o", ovf, 1);
`endif
        alu(0, 1, ALU_SUB);        check("subneg_y", y, 32'hFFFFFFFF); check("subneg_c", cout, 0);
`ifdef ALU_OVERFLOW_EN
        check("subneg_o", ovf, 0);
`endif
        alu(32'h1C, 32'h08, ALU_ADD); check("add1c_y", y, 32'h24);
        alu(32'hFFFFFFFF, 1, ALU_SLT); check("slt_neg_y", y, 1);
        alu(1, 32'hFFFFFFFF, ALU_SLT); check("slt_pos_y", y, 0);
        alu(32'h80000000, 1, ALU_SLT); check("slt_ovf_y", y, 1);

        for (int i = 0; i <= 30; i++) wr(i * 4, i);
        for (int i = 0; i <= 30; i++) rd($sformatf("fill_%0d", i), i * 4, i);
        oe = 0; #1 check("oe_off", d_out, 0);
        oe = 1; cs_ram = 0; #1 check("cs_off", d_out, 0);
        @(negedge clk);
        cs_ram = 1; oe = 1; d_in = 5; alu(0, 20, ALU_ADD); we = 1;
        #1 check("we_prio", d_out, 0);
        we = 0;

        wr(32'h04, 32'hDEADBEEF);
        rd("wrap_104", 32'h104, 32'hDEADBEEF);
        rd("align_07", 32'h07, 32'hDEADBEEF);
        rd("keep_08", 32'h08, 2);

        @(negedge clk);
        #2 rst = 1;
        rd("rst_hold", 32'h08, 0);
        #1 rst = 0;
        for (int i = 0; i <= 30; i++) rd($sformatf("clr_%0d", i), i * 4, 0);

        @(negedge clk);
        rst = 1; cs_ram = 1; we = 1; oe = 0; d_in = 32'h55; alu(0, 8, ALU_ADD);
        @(posedge clk);
        #1 we = 0; rst = 0;
        rd("rst_blk", 8, 0);
        wr(8, 32'h1234);
        rd("post_rst", 8, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
